id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage pipeline, directly upstream of the ALU. It registers decoded operands and control from ID and applies EX/MEM and MEM/WB forwarding to drive the ALU ports `a_input`, `b_input`, `sa` and `opcode`. It detects load-use hazards and inserts bubbles, and it supports downstream stall and branch flush.

---
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use hazard detection
//
// Captures decoded operands and control from ID, then forwards EX/MEM and
// MEM/WB results onto the ALU operand ports. The load-use detector inserts
// one bubble per hazard. Downstream stall and branch flush are also supported.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_*                  decoded instruction fields and control from ID
//   stall                 downstream stall, EX contents are held
//   flush                 branch flush, a bubble is loaded (beats stall)
//   exmem_*, memwb_*      forwarding sources (write enable, index, result)
//   a_input, b_input      forwarded ALU operands (b_input selects the immediate)
//   sa, opcode            shift amount and opcode to the ALU
//   ex_store_data         forwarded rt value for stores
//   ex_rd, ex_valid, ex_* destination index and control travelling to MEM
//   hazard_stall          load-use hazard, so IF/ID and PC must hold

module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_rd,
    input  logic [4:0]       id_sa,
    input  logic [3:0]       id_opcode,
    input  logic             id_use_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             stall,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [REGW-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [REGW-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] a_input,
    output logic [WIDTH-1:0] b_input,
    output logic [4:0]       sa,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [REGW-1:0]  ex_rd,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             hazard_stall
);

    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic [WIDTH-1:0] r_imm;
    logic [REGW-1:0]  r_rs;
    logic [REGW-1:0]  r_rt;
    logic [REGW-1:0]  r_rd;
    logic [4:0]       r_sa;
    logic [3:0]       r_opcode;
    logic             r_use_imm;
    logic             r_valid;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_to_reg;

    logic             w_load_hazard;
    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;

    // Register 0 is hard-wired, so it is never forwarded. EX/MEM is checked
    // first because it holds the younger result.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [REGW-1:0]  idx,
        input logic [WIDTH-1:0] raw,
        input logic             em_we,
        input logic [REGW-1:0]  em_rd,
        input logic [WIDTH-1:0] em_res,
        input logic             mw_we,
        input logic [REGW-1:0]  mw_rd,
        input logic [WIDTH-1:0] mw_res
    );
        logic [WIDTH-1:0] v;
        v = raw;
        if (idx != '0) begin
            if (em_we && (em_rd == idx)) begin
                v = em_res;
            end else if (mw_we && (mw_rd == idx)) begin
                v = mw_res;
            end
        end
        return v;
    endfunction

    // The rt match is made even when ID does not read rt. This is
    // conservative but keeps the detector independent of the decoder.
    // A flush kills the dependent instruction, so no hold is requested.
    always_comb begin
        w_load_hazard = 1'b0;
        if (!flush && r_valid && r_mem_read && (r_rd != '0) && id_valid &&
            ((r_rd == id_rs) || (r_rd == id_rt))) begin
            w_load_hazard = 1'b1;
        end
    end

    always_comb begin
        w_fwd_rs = fwd(r_rs, r_rs_data, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_result);
        w_fwd_rt = fwd(r_rt, r_rt_data, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_result);
    end

    // Priority: flush > stall > load-use bubble > normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_sa         <= '0;
            r_opcode     <= '0;
            r_use_imm    <= 1'b0;
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (flush || (!stall && w_load_hazard)) begin
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_sa         <= '0;
            r_opcode     <= '0;
            r_use_imm    <= 1'b0;
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rd         <= id_rd;
            r_sa         <= id_sa;
            r_opcode     <= id_opcode;
            r_use_imm    <= id_use_imm;
            r_valid      <= id_valid;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
        end
    end

    assign a_input       = w_fwd_rs;
    assign b_input       = r_use_imm ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign sa            = r_sa;
    assign opcode        = r_opcode;
    assign ex_rd         = r_rd;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign hazard_stall  = w_load_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with an instruction-level model
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_sa;
    logic [3:0]  id_opcode;
    logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] a_input, b_input, ex_store_data;
    logic [4:0]  sa, ex_rd;
    logic [3:0]  opcode;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        hazard_stall;

    int npass = 0;
    int ntot  = 0;

    id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_sa(id_sa),
        .id_opcode(id_opcode), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .a_input(a_input), .b_input(b_input), .sa(sa), .opcode(opcode),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as an abstract record.
    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, use_imm;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, sa;
        logic [3:0]  op;
    } instr_t;

    instr_t m = '0;

    function automatic instr_t id_instr();
        instr_t t;
        t.valid = id_valid; t.rw = id_reg_write; t.mr = id_mem_read;
        t.mw = id_mem_write; t.m2r = id_mem_to_reg; t.use_imm = id_use_imm;
        t.rs_data = id_rs_data; t.rt_data = id_rt_data; t.imm = id_imm;
        t.rs = id_rs; t.rt = id_rt; t.rd = id_rd; t.sa = id_sa; t.op = id_opcode;
        return t;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] raw);
        if (idx == 5'd0) return raw;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return raw;
    endfunction

    function automatic logic load_use();
        return !flush && m.valid && m.mr && m.rd != 5'd0 && id_valid &&
               (m.rd == id_rs || m.rd == id_rt);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m = '0;
        else if (flush) m = '0;
        else if (stall) m = m;
        else if (load_use()) m = '0;
        else m = id_instr();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("m_a_input", a_input, operand(m.rs, m.rs_data));
        chk("m_b_input", b_input, m.use_imm ? m.imm : operand(m.rt, m.rt_data));
        chk("m_store", ex_store_data, operand(m.rt, m.rt_data));
        chk("m_sa", {27'd0, sa}, {27'd0, m.sa});
        chk("m_opcode", {28'd0, opcode}, {28'd0, m.op});
        chk("m_rd", {27'd0, ex_rd}, {27'd0, m.rd});
        chk("m_ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {27'd0, m.valid, m.rw, m.mr, m.mw, m.m2r});
        chk("m_hazard", {31'd0, hazard_stall}, {31'd0, load_use()});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_sa = 0; id_opcode = 0;
        id_use_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        idle();
        stall = 0; flush = 0;
        #1 rst_n = 0;
        step(); step();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_a", a_input, 32'd0);
        rst_n = 1;

        // plain load
        id_valid = 1; id_rs_data = 32'd5; id_rt_data = 32'hFFFFFFFE; id_opcode = 4'b0010;
        id_sa = 5'd3; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd5; id_reg_write = 1;
        step();
        idle();
        #1;
        chk("plain_a", a_input, 32'd5);
        chk("plain_b", b_input, 32'hFFFFFFFE);
        chk("plain_sa", {27'd0, sa}, 32'd3);
        chk("plain_op", {28'd0, opcode}, 32'd2);
        chk("plain_valid", {31'd0, ex_valid}, 32'd1);

        // forwarding priority
        id_valid = 1; id_rs = 5'd4; id_rs_data = 32'h99;
        step();
        idle();
        exmem_reg_write = 1; exmem_rd = 5'd4; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd4; memwb_result = 32'h22;
        #1 chk("fwd_exmem", a_input, 32'h11);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", a_input, 32'h22);
        id_valid = 1; id_rs = 5'd0; id_rs_data = 32'h33;
        step();
        idle();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'h22;
        #1 chk("fwd_r0", a_input, 32'h33);

        // immediate select
        idle();
        id_valid = 1; id_use_imm = 1; id_imm = 32'hFFFF8000; id_rt = 5'd6; id_rt_data = 32'h44;
        step();
        idle();
        exmem_reg_write = 1; exmem_rd = 5'd6; exmem_result = 32'hABC;
        #1;
        chk("imm_b", b_input, 32'hFFFF8000);
        chk("imm_store", ex_store_data, 32'hABC);

        // load-use
        idle();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_rd = 5'd3;
        step();
        idle();
        id_valid = 1; id_rs = 5'd3; id_rs_data = 32'h1; id_rt = 5'd7; id_rt_data = 32'h2;
        id_opcode = 4'd1; id_rd = 5'd4; id_reg_write = 1;
        #1 chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
        step();
        #1;
        chk("lu_bubble_ctrl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_to_reg}, 32'd0);
        chk("lu_hazard_drop", {31'd0, hazard_stall}, 32'd0);
        step();
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h7;
        #1;
        chk("lu_fwd_a", a_input, 32'h7);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);

        // stall holds, forwarding still tracks
        stall = 1; id_rs_data = 32'h55; id_opcode = 4'd9;
        step(); step();
        #1;
        chk("stall_a", a_input, 32'h7);
        chk("stall_op", {28'd0, opcode}, 32'd1);
        memwb_result = 32'h8;
        #1 chk("stall_track", a_input, 32'h8);

        // stall and flush together
        flush = 1;
        step();
        flush = 0; stall = 0;
        #1;
        chk("sf_valid", {31'd0, ex_valid}, 32'd0);
        chk("sf_rw", {31'd0, ex_reg_write}, 32'd0);

        // stall with hazard, then flush with hazard
        idle();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd9;
        step();
        idle();
        id_valid = 1; id_rs = 5'd2; id_rt = 5'd9;
        #1 chk("sh_hazard", {31'd0, hazard_stall}, 32'd1);
        stall = 1;
        step();
        #1;
        chk("sh_load_held", {31'd0, ex_mem_read}, 32'd1);
        chk("sh_rd_held", {27'd0, ex_rd}, 32'd9);
        chk("sh_hazard_on", {31'd0, hazard_stall}, 32'd1);
        stall = 0; flush = 1;
        #1 chk("fh_hazard", {31'd0, hazard_stall}, 32'd0);
        step();
        flush = 0;
        #1;
        chk("fh_valid", {31'd0, ex_valid}, 32'd0);
        chk("fh_rd", {27'd0, ex_rd}, 32'd0);

        // reset mid-operation
        idle();
        id_valid = 1; id_rs = 5'd1; id_rs_data = 32'h77; id_opcode = 4'd3; id_reg_write = 1; id_rd = 5'd2;
        step();
        #1 chk("pre_rst_a", a_input, 32'h77);
        rst_n = 0;
        #1;
        chk("mid_rst_a", a_input, 32'd0);
        chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_op", {28'd0, opcode}, 32'd0);
        chk("mid_rst_rd", {27'd0, ex_rd}, 32'd0);
        step();
        rst_n = 1;
        step();
        #1;
        chk("post_rst_a", a_input, 32'h77);
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
